dm_cache_ctrl: RTL and testbench

//  Write-back, write-allocate controller for the direct-mapped cache (1024 lines x 128 bit).
//  - Sits between the CPU load/store port, the cache_data_store array and the main-memory port.
//  - Owns the tag/valid/dirty state and sequences every data-store access.
//  - Sequences line refill and dirty-line writeback over a req/ready memory handshake.

---
 rtl/dm_cache_pkg.sv | 15 +
 rtl/dm_cache_tag_store.sv | 26 ++
 rtl/dm_cache_ctrl.sv | 112 +++++++++++
 tb/tb_dm_cache_ctrl.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/dm_cache_pkg.sv
// dm_cache_pkg: shared widths, FSM states and tag entry layout for the direct-mapped cache
package dm_cache_pkg;
  localparam int ADDR_W = 32;
  localparam int WORD_W = 32;
  localparam int LINE_W = 128;
  localparam int INDEX_W = 10;
  localparam int OFF_W = 4;
  localparam int TAG_W = ADDR_W - INDEX_W - OFF_W;
  typedef enum logic [1:0] {IDLE, COMPARE, WRITEBACK, ALLOCATE} state_t;
  typedef struct packed {
    logic valid;
    logic dirty;
    logic [TAG_W-1:0] tag;
  } tag_entry_t;
endpackage

// File: rtl/dm_cache_tag_store.sv
// dm_cache_tag_store: 1024-entry tag/valid/dirty array, combinational read, synchronous write
module dm_cache_tag_store
  import dm_cache_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [INDEX_W-1:0] index,
  output tag_entry_t         rentry,
  input  logic               we,
  input  tag_entry_t         wentry
);
  logic [2**INDEX_W-1:0] valid, dirty;
  logic [TAG_W-1:0] tags [2**INDEX_W];
  assign rentry = '{valid: valid[index], dirty: dirty[index], tag: tags[index]};
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      valid <= '0;
      dirty <= '0;
    end else if (we) begin
      valid[index] <= wentry.valid;
      dirty[index] <= wentry.dirty;
    end
  // tags stay unreset: they are meaningless while valid is clear
  always_ff @(posedge clk)
    if (we) tags[index] <= wentry.tag;
endmodule

// File: rtl/dm_cache_ctrl.sv
// dm_cache_ctrl: write-back, write-allocate direct-mapped cache controller
module dm_cache_ctrl
  import dm_cache_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               cpu_req,
  input  logic               cpu_we,
  input  logic [ADDR_W-1:0]  cpu_addr,
  input  logic [WORD_W-1:0]  cpu_wdata,
  output logic               cpu_ready,
  output logic [WORD_W-1:0]  cpu_rdata,
  output logic [INDEX_W-1:0] ds_index,
  output logic [LINE_W-1:0]  ds_wdata,
  output logic               ds_we,
  input  logic [LINE_W-1:0]  ds_rdata,
  output logic               mem_req,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [LINE_W-1:0]  mem_wdata,
  input  logic [LINE_W-1:0]  mem_rdata,
  input  logic               mem_ready
);
  state_t state, state_n;
  logic req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [WORD_W-1:0] req_wdata;
  logic [TAG_W-1:0] tag;
  logic [1:0] off;
  logic [LINE_W-1:0] merged;
  tag_entry_t te_r, te_w;
  logic te_we, hit, dirty_victim;
  assign ds_index = req_addr[OFF_W+:INDEX_W];
  assign tag = req_addr[ADDR_W-1-:TAG_W];
  assign off = req_addr[3:2];
  assign hit = te_r.valid && te_r.tag == tag;
  assign dirty_victim = te_r.valid && te_r.dirty;
  dm_cache_tag_store u_tags (
    .clk(clk), .reset(reset), .index(ds_index), .rentry(te_r), .we(te_we), .wentry(te_w)
  );
  always_comb begin
    merged = ds_rdata;
    merged[WORD_W*off+:WORD_W] = req_wdata;
  end
  always_comb begin
    state_n = state;
    cpu_ready = 1'b0;
    cpu_rdata = '0;
    ds_we = 1'b0;
    ds_wdata = '0;
    te_we = 1'b0;
    te_w = te_r;
    case (state)
      IDLE: state_n = cpu_req ? COMPARE : IDLE;
      COMPARE:
        if (hit) begin
          cpu_ready = 1'b1;
          state_n = IDLE;
          cpu_rdata = req_we ? '0 : ds_rdata[WORD_W*off+:WORD_W];
          ds_we = req_we;
          ds_wdata = req_we ? merged : '0;
          te_we = req_we;
          te_w.dirty = 1'b1;
        end else state_n = dirty_victim ? WRITEBACK : ALLOCATE;
      WRITEBACK:
        if (mem_ready) begin
          te_we = 1'b1;
          te_w.dirty = 1'b0;
          state_n = ALLOCATE;
        end
      ALLOCATE:
        if (mem_ready) begin
          ds_we = 1'b1;
          ds_wdata = mem_rdata;
          te_we = 1'b1;
          te_w = '{valid: 1'b1, dirty: 1'b0, tag: tag};
          state_n = COMPARE;
        end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      req_we <= 1'b0;
      req_addr <= '0;
      req_wdata <= '0;
      mem_req <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && cpu_req) begin
        req_we <= cpu_we;
        req_addr <= cpu_addr;
        req_wdata <= cpu_wdata;
      end
      // mem_* are registered so they change only on entry to WRITEBACK/ALLOCATE
      if (state == COMPARE && !hit) begin
        mem_req <= 1'b1;
        mem_we <= dirty_victim;
        mem_addr <= {dirty_victim ? te_r.tag : tag, ds_index, 4'b0};
        mem_wdata <= ds_rdata;
      end
      if (state == WRITEBACK && mem_ready) begin
        mem_we <= 1'b0;
        mem_addr <= {tag, ds_index, 4'b0};
      end
      if (state == ALLOCATE && mem_ready) mem_req <= 1'b0;
    end
endmodule

// File: tb/tb_dm_cache_ctrl.sv
// tb_dm_cache_ctrl: table-driven check of the cache controller against a data-store and memory model
module tb_dm_cache_ctrl;
  logic clk = 1'b0, reset = 1'b0;
  logic cpu_req = 1'b0, cpu_we = 1'b0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0;
  logic cpu_ready, ds_we, mem_req, mem_we;
  logic [31:0] cpu_rdata, mem_addr;
  logic [9:0] ds_index;
  logic [127:0] ds_wdata, ds_rdata, mem_wdata;
  logic [127:0] mem_rdata = '0;
  logic mem_ready = 1'b0;
  int checks = 0, errors = 0;
  int lat = 1, wait_cnt = 0;
  bit stray = 1'b0;
  logic [31:0] last_wb = '1;
  logic [127:0] mem_m [logic [31:0]];
  logic [127:0] ds_m [1024];
  always #5 clk = ~clk;
  dm_cache_ctrl dut (
    .clk(clk), .reset(reset), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata), .ds_index(ds_index),
    .ds_wdata(ds_wdata), .ds_we(ds_we), .ds_rdata(ds_rdata), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );
  assign ds_rdata = ds_m[ds_index];
  always @(posedge clk) if (ds_we) ds_m[ds_index] <= ds_wdata;
  function automatic logic [127:0] dflt(input logic [31:0] a);
    return {a + 32'd3, a + 32'd2, a + 32'd1, a};
  endfunction
  initial forever begin
    @(negedge clk);
    mem_ready = 1'b0;
    if (stray) begin
      mem_ready = 1'b1;
      stray = 1'b0;
    end else if (mem_req && reset) begin
      if (wait_cnt >= lat - 1) begin
        mem_ready = 1'b1;
        wait_cnt = 0;
        if (mem_we) begin
          mem_m[mem_addr] = mem_wdata;
          last_wb = mem_addr;
        end else mem_rdata = mem_m.exists(mem_addr) ? mem_m[mem_addr] : dflt(mem_addr);
      end else wait_cnt++;
    end else wait_cnt = 0;
  end
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  typedef struct {
    logic we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int lat;
    logic [31:0] rdata;
    int cyc;
    int fills;
    int wbs;
    int dswe;
  } vec_t;
  int n, fills, wbs, dswe, readies, memreq_cyc;
  logic [31:0] got;
  task automatic run_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata, input int l);
    @(negedge clk);
    #2;
    lat = l;
    cpu_req = 1'b1;
    cpu_we = we;
    cpu_addr = addr;
    cpu_wdata = wdata;
    n = 0; fills = 0; wbs = 0; dswe = 0; readies = 0; memreq_cyc = 0; got = '0;
    while (readies == 0 && n < 300) begin
      @(negedge clk);
      #2;
      n++;
      if (mem_req) memreq_cyc++;
      if (mem_req && mem_ready && !mem_we) fills++;
      if (mem_req && mem_ready && mem_we) wbs++;
      if (ds_we) dswe++;
      if (cpu_ready) begin
        readies++;
        got = cpu_rdata;
        cpu_req = 1'b0;
      end
    end
    if (readies == 0) begin
      errors++;
      $display("FAIL timeout: no cpu_ready for addr %h after %0d cycles", addr, n);
      cpu_req = 1'b0;
    end
  endtask
  task automatic run_vec(input vec_t v, input int i);
    string s;
    run_req(v.we, v.addr, v.wdata, v.lat);
    s = $sformatf("v%0d", i);
    if (!v.we) check({s, " rdata"}, 128'(got), 128'(v.rdata));
    check({s, " cycles"}, 128'(n), 128'(v.cyc));
    check({s, " fills"}, 128'(fills), 128'(v.fills));
    check({s, " writebacks"}, 128'(wbs), 128'(v.wbs));
    check({s, " ds_we pulses"}, 128'(dswe), 128'(v.dswe));
  endtask
  vec_t vt [13];
  initial begin
    mem_m[32'h10] = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
    vt[0]  = '{0, 32'h0000_0010, 0, 1, 32'h1111_1111, 3, 1, 0, 1};
    vt[1]  = '{0, 32'h0000_0014, 0, 1, 32'h2222_2222, 1, 0, 0, 0};
    vt[2]  = '{1, 32'h0000_0018, 32'hDEAD_BEEF, 1, 0, 1, 0, 0, 1};
    vt[3]  = '{0, 32'h0000_0018, 0, 1, 32'hDEAD_BEEF, 1, 0, 0, 0};
    vt[4]  = '{0, 32'h0000_4010, 0, 2, 32'h0000_4010, 6, 1, 1, 1};
    vt[5]  = '{0, 32'h0000_0018, 0, 1, 32'hDEAD_BEEF, 3, 1, 0, 1};
    vt[6]  = '{1, 32'h0000_3FF0, 32'hCAFE_F00D, 3, 0, 5, 1, 0, 2};
    vt[7]  = '{0, 32'h0000_3FF0, 0, 1, 32'hCAFE_F00D, 1, 0, 0, 0};
    vt[8]  = '{0, 32'h0000_3FF4, 0, 1, 32'h0000_3FF1, 1, 0, 0, 0};
    vt[9]  = '{0, 32'h8000_3FF0, 0, 1, 32'h8000_3FF0, 4, 1, 1, 1};
    vt[10] = '{0, 32'h0000_0000, 0, 1, 32'h0000_0000, 3, 1, 0, 1};
    vt[11] = '{1, 32'h0000_000C, 32'h1234_5678, 1, 0, 1, 0, 0, 1};
    vt[12] = '{0, 32'h0000_000C, 0, 1, 32'h1234_5678, 1, 0, 0, 0};
    #12;
    check("reset cpu_ready", 128'(cpu_ready), 0);
    check("reset ds_we", 128'(ds_we), 0);
    check("reset mem_req", 128'(mem_req), 0);
    check("reset mem_we", 128'(mem_we), 0);
    check("reset mem_addr", 128'(mem_addr), 0);
    check("reset mem_wdata", mem_wdata, 0);
    check("reset ds_index", 128'(ds_index), 0);
    check("reset ds_wdata", ds_wdata, 0);
    check("reset cpu_rdata", 128'(cpu_rdata), 0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 13; i++) begin
      run_vec(vt[i], i);
      if (i == 4) begin
        check("wb addr", 128'(last_wb), 128'h10);
        check("wb line", mem_m[32'h10], {32'h4444_4444, 32'hDEAD_BEEF, 32'h2222_2222, 32'h1111_1111});
      end
      if (i == 9) check("wb addr idx1023", 128'(last_wb), 128'h3FF0);
      if (i == 9) check("wb line idx1023", mem_m[32'h3FF0], {32'h3FF3, 32'h3FF2, 32'h3FF1, 32'hCAFE_F00D});
    end
    run_req(0, 32'h0000_0000, 0, 1);
    check("index0 hit mem_req cycles", 128'(memreq_cyc), 0);
    // reset in the middle of a long fill
    @(negedge clk);
    #2;
    lat = 50;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_4010;
    n = 0;
    while (!(mem_req && !mem_we) && n < 20) begin
      @(negedge clk);
      #2;
      n++;
    end
    check("allocate reached", 128'(mem_req && !mem_we), 1);
    check("allocate addr", 128'(mem_addr), 128'h4010);
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check("rst mem_req drop", 128'(mem_req), 0);
    check("rst cpu_ready", 128'(cpu_ready), 0);
    check("rst ds_we", 128'(ds_we), 0);
    check("rst mem_addr", 128'(mem_addr), 0);
    cpu_req = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    run_req(0, 32'h0000_4010, 0, 1);
    check("post-rst miss rdata", 128'(got), 128'h4010);
    check("post-rst miss cycles", 128'(n), 3);
    check("post-rst fills", 128'(fills), 1);
    check("post-rst no wb", 128'(wbs), 0);
    // a stray mem_ready while idle must not disturb anything
    @(negedge clk);
    stray = 1'b1;
    repeat (2) @(negedge clk);
    check("stray no mem_req", 128'(mem_req), 0);
    run_req(0, 32'h0000_4014, 0, 1);
    check("stray then hit rdata", 128'(got), 128'h4011);
    check("stray then hit cycles", 128'(n), 1);
    check("stray then hit mem_req", 128'(memreq_cyc), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
